// File: rtl/yannickreiss_muldiv_seq.sv
// yannickreiss_muldiv_seq
// Sequential multiply/divide unit. One shift-add (multiply) or one
// restoring-subtract (divide) step per clock, with a start/busy/done
// handshake and a divide-by-zero flag.
//
// Optional feature macro: MULDIV_SIGNED_EN
//   defined   -> signed_op port exists; signed_op=1 treats a/b as two's
//                complement (magnitudes are iterated, sign fixed on DONE entry)
//   undefined -> unsigned only, no signed_op port
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   start      request, accepted only in IDLE or DONE
//   op         0 = multiply, 1 = divide (latched with start)
//   a, b       operands (latched with start)
//   signed_op  signed operation select (MULDIV_SIGNED_EN only)
//   busy       high while iterating
//   done       one-cycle completion pulse
//   result     product, or {remainder, quotient} for divide
//   div_zero   last accepted divide had b == 0
module yannickreiss_muldiv_seq #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
`ifdef MULDIV_SIGNED_EN
    input  logic               signed_op,
`endif
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               div_zero
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Latched operation context
    logic               op_q;
    logic               neg_res_q;  // product / quotient must be negated
    logic               neg_rem_q;  // remainder must be negated
    logic [CW-1:0]      cnt_q;

    // Multiply datapath
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;

    // Divide datapath
    logic [WIDTH:0]     rem_q;
    logic [WIDTH-1:0]   quo_q;
    logic [WIDTH-1:0]   dvsr_q;

    // Control strobes from the FSM
    logic accept;
    logic dz;
    logic last_step;

    // ------------------------------------------------------------------
    // Operand sign handling
    // ------------------------------------------------------------------
    logic             sgn_a, sgn_b;
    logic [WIDTH-1:0] mag_a, mag_b;

`ifdef MULDIV_SIGNED_EN
    assign sgn_a = signed_op & a[WIDTH-1];
    assign sgn_b = signed_op & b[WIDTH-1];
`else
    assign sgn_a = 1'b0;
    assign sgn_b = 1'b0;
`endif

    // The most-negative value maps onto itself, which read unsigned is
    // exactly its magnitude, so no extra bit is needed.
    assign mag_a = sgn_a ? (~a + 1'b1) : a;
    assign mag_b = sgn_b ? (~b + 1'b1) : b;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        dz        = 1'b0;
        last_step = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    accept = 1'b1;
                    // Divide by zero skips iteration entirely
                    if (op && (b == '0)) begin
                        dz      = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (cnt_q == LAST) begin
                    last_step = 1'b1;
                    state_d   = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

    // ------------------------------------------------------------------
    // One iteration step (both datapaths advance; op_q picks the answer)
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     rem_step;
    logic [WIDTH-1:0]   quo_step;
    logic               rem_ge;

    always_comb begin
        acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
        // Shift the next dividend bit into the partial remainder, then
        // keep the subtraction only if it does not go negative.
        rem_sh   = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        rem_ge   = (rem_sh >= {1'b0, dvsr_q});
        rem_step = rem_ge ? (rem_sh - {1'b0, dvsr_q}) : rem_sh;
        quo_step = {quo_q[WIDTH-2:0], rem_ge};
    end

    // After a restore step the remainder is below the divisor, so the top
    // bit of the partial remainder never carries into the next shift.
    logic unused_rem_msb;
    assign unused_rem_msb = rem_q[WIDTH];

    // ------------------------------------------------------------------
    // Sign correction applied on the RUN -> DONE transition
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;
    logic [2*WIDTH-1:0] final_res;

    always_comb begin
        prod_fix  = neg_res_q ? (~acc_step + 1'b1) : acc_step;
        q_fix     = neg_res_q ? (~quo_step + 1'b1) : quo_step;
        r_fix     = neg_rem_q ? (~rem_step[WIDTH-1:0] + 1'b1) : rem_step[WIDTH-1:0];
        final_res = op_q ? {r_fix, q_fix} : prod_fix;
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q      <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            result    <= '0;
            div_zero  <= 1'b0;
        end else if (accept) begin
            op_q      <= op;
            neg_res_q <= sgn_a ^ sgn_b;
            neg_rem_q <= sgn_a;  // remainder follows the dividend
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= {{WIDTH{1'b0}}, mag_a};
            mplier_q  <= mag_b;
            rem_q     <= '0;
            quo_q     <= mag_a;
            dvsr_q    <= mag_b;
            div_zero  <= dz;
            // Divide by zero: quotient all ones, remainder is the raw dividend
            if (dz) begin
                result <= {a, {WIDTH{1'b1}}};
            end
        end else if (state_q == RUN) begin
            cnt_q    <= cnt_q + 1'b1;
            acc_q    <= acc_step;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            rem_q    <= rem_step;
            quo_q    <= quo_step;
            if (last_step) begin
                result <= final_res;
            end
        end
    end

endmodule

// File: tb/tb_yannickreiss_muldiv_seq.sv
// Self-checking bench for yannickreiss_muldiv_seq (WIDTH=4): directed cases
// plus randomized operations checked against an arithmetic reference model.
module tb_yannickreiss_muldiv_seq;

    localparam int W  = 4;
    localparam int W2 = 2 * W;
    localparam int M  = (1 << W) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          op;
    logic          signed_op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          busy;
    logic          done;
    logic [W2-1:0] result;
    logic          div_zero;

    int n_vec = 0;
    int n_err = 0;

    logic [W2-1:0] exp_res;
    logic          exp_dz;

    always #5 clk = ~clk;

    yannickreiss_muldiv_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
`ifdef MULDIV_SIGNED_EN
        .signed_op(signed_op),
`endif
        .busy     (busy),
        .done     (done),
        .result   (result),
        .div_zero (div_zero)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic on the operand values.
    task automatic model(input bit mop, input int ua, input int ub, input bit sg,
                         output logic [W2-1:0] r, output logic dzo);
        int sa, sb, q, rm;
        sa  = (sg && ua > M / 2) ? ua - (M + 1) : ua;
        sb  = (sg && ub > M / 2) ? ub - (M + 1) : ub;
        dzo = 1'b0;
        if (!mop) begin
            r = W2'(sa * sb);
        end else if (ub == 0) begin
            dzo = 1'b1;
            r   = {W'(ua), W'(M)};
        end else begin
            q  = sa / sb;   // truncates toward zero
            rm = sa % sb;   // takes the dividend's sign
            r  = {W'(rm), W'(q)};
        end
    endtask

    // Drive a start for one edge, then scramble the inputs (must be ignored).
    task automatic issue(input bit mop, input int ua, input int ub, input bit sg);
        op        = mop;
        a         = W'(ua);
        b         = W'(ub);
        signed_op = sg;
        start     = 1'b1;
        model(mop, ua, ub, sg, exp_res, exp_dz);
        tick();
        start     = 1'b0;
        op        = 1'($urandom);
        a         = W'($urandom);
        b         = W'($urandom);
        signed_op = 1'($urandom);
    endtask

    // Called in cycle 1; returns in the DONE cycle.
    task automatic complete(input string tag, input bit poke);
        if (!exp_dz) begin
            for (int i = 1; i <= W; i++) begin
                chk({tag, ".busy"}, 32'(busy), 1);
                chk({tag, ".done_early"}, 32'(done), 0);
                if (poke && i == 2) begin
                    start = 1'b1;
                    op    = 1'b0;
                    a     = W'(2);
                    b     = W'(2);
                end else begin
                    start = 1'b0;
                end
                tick();
            end
            start = 1'b0;
        end else begin
            chk({tag, ".busy_dz"}, 32'(busy), 0);
        end
        chk({tag, ".done"}, 32'(done), 1);
        chk({tag, ".busy_at_done"}, 32'(busy), 0);
        chk({tag, ".result"}, 32'(result), 32'(exp_res));
        chk({tag, ".div_zero"}, 32'(div_zero), 32'(exp_dz));
    endtask

    // One cycle without start: done must drop, result must hold.
    task automatic idle(input string tag);
        start = 1'b0;
        tick();
        chk({tag, ".done_drop"}, 32'(done), 0);
        chk({tag, ".busy_idle"}, 32'(busy), 0);
        chk({tag, ".hold_res"}, 32'(result), 32'(exp_res));
        chk({tag, ".hold_dz"}, 32'(div_zero), 32'(exp_dz));
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        op        = 1'b0;
        a         = '0;
        b         = '0;
        signed_op = 1'b0;
        tick();
        tick();
        chk("rst.busy", 32'(busy), 0);
        chk("rst.done", 32'(done), 0);
        chk("rst.result", 32'(result), 0);
        chk("rst.div_zero", 32'(div_zero), 0);
        reset = 1'b0;
        tick();

        // Multiply 7x5 with an ignored start in cycle 2, then back-to-back 15x15
        issue(0, 7, 5, 0);
        complete("mul7x5", 1'b1);
        chk("mul7x5.const", 32'(result), 32'h23);
        issue(0, 15, 15, 0);
        complete("b2b15x15", 1'b0);
        chk("b2b15x15.const", 32'(result), 32'hE1);
        idle("b2b");

        // Divide 13/4
        issue(1, 13, 4, 0);
        complete("div13by4", 1'b0);
        chk("div13by4.const", 32'(result), 32'h13);
        idle("div");

        // Divide by zero, then back-to-back from the short DONE
        issue(1, 9, 0, 0);
        complete("div9by0", 1'b0);
        chk("div9by0.const", 32'(result), 32'h9F);
        issue(0, 3, 3, 0);
        complete("after_dz", 1'b0);
        idle("after_dz");

        // Reset in cycle 3 discards the operation
        issue(0, 7, 5, 0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst.busy", 32'(busy), 0);
        chk("midrst.done", 32'(done), 0);
        chk("midrst.result", 32'(result), 0);
        chk("midrst.div_zero", 32'(div_zero), 0);
        exp_res = '0;
        exp_dz  = 1'b0;
        for (int i = 0; i < W + 2; i++) begin
            chk("midrst.no_done", 32'(done), 0);
            tick();
        end

        // Reset wins over a simultaneous start
        reset = 1'b1;
        start = 1'b1;
        op    = 1'b1;
        a     = W'(5);
        b     = W'(0);
        tick();
        reset = 1'b0;
        start = 1'b0;
        chk("rstwin.busy", 32'(busy), 0);
        chk("rstwin.done", 32'(done), 0);
        chk("rstwin.div_zero", 32'(div_zero), 0);
        idle("rstwin");

        // Normal operation after reset
        issue(1, 14, 3, 0);
        complete("post_rst", 1'b0);
        idle("post_rst");

`ifdef MULDIV_SIGNED_EN
        issue(1, 9, 2, 1);
        complete("sdiv_m7by2", 1'b0);
        chk("sdiv_m7by2.const", 32'(result), 32'hFD);
        idle("sdiv_m7by2");
        issue(1, 8, 15, 1);
        complete("sdiv_m8bym1", 1'b0);
        chk("sdiv_m8bym1.const", 32'(result), 32'h08);
        idle("sdiv_m8bym1");
        issue(0, 13, 5, 1);
        complete("smul_m3x5", 1'b0);
        chk("smul_m3x5.const", 32'(result), 32'hF1);
        idle("smul_m3x5");
`endif

        // Randomized operations, some back-to-back
        for (int n = 0; n < 60; n++) begin
            bit rop, rsg;
            int ra, rb;
            rop = 1'($urandom);
            ra  = int'($urandom_range(0, M));
            rb  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, M));
`ifdef MULDIV_SIGNED_EN
            rsg = 1'($urandom);
`else
            rsg = 1'b0;
`endif
            issue(rop, ra, rb, rsg);
            complete("rand", 1'($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 0) begin
                idle("rand");
            end
        end
        idle("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
